// File: rtl/ir_conv_engine.sv
//==============================================================================
// Module      : ir_conv_engine
// Description : Sweeps the IR/history buffers once per audio sample and
//               accumulates the 8-tap MAC into one Q15 convolution result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ir_conv_engine #(
    parameter int PAIRS        = 3000,
    parameter int BRAM_LATENCY = 2,
    parameter int ACC_WIDTH    = 52,
    parameter int OUT_SHIFT    = 15
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               sample_valid,
    input  logic               ir_loading,
    input  logic [7:0][15:0]   ir_vals,
    input  logic [7:0][15:0]   hist_vals,
    output logic [12:0]        first_ir_index,
    output logic [12:0]        second_ir_index,
    output logic               busy,
    output logic signed [15:0] out_sample,
    output logic               out_valid,
    output logic               overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] C_HALF = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] C_MAX  = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] C_MIN  = ACC_WIDTH'(-32768);
    localparam logic [11:0]                 C_LAST = 12'(PAIRS - 1);

    state_t                        state_q, state_d;
    logic [11:0]                   j_q, j_d;
    logic [12:0]                   first_q, first_d;
    logic [12:0]                   second_q, second_d;
    logic                          issue_q, issue_d;
    logic [BRAM_LATENCY-1:0]       vpipe_q, vpipe_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [15:0]            out_q, out_d;
    logic                          overrun_q, overrun_d;

    logic signed [31:0]            w_prod [8];
    logic signed [ACC_WIDTH-1:0]   w_tap_sum;
    logic signed [ACC_WIDTH-1:0]   w_rnd;
    logic signed [ACC_WIDTH-1:0]   w_shift;
    logic signed [15:0]            w_sat;
    logic [BRAM_LATENCY:0]         w_vchain;
    logic                          w_sweeping;

    // Full-precision adder tree: every 32-bit product is sign-extended first.
    always_comb begin
        w_tap_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_prod[i] = $signed(ir_vals[i]) * $signed(hist_vals[i]);
            w_tap_sum = w_tap_sum + {{(ACC_WIDTH-32){w_prod[i][31]}}, w_prod[i]};
        end
    end

    // Round half toward +inf, then clamp to the 16-bit signed range.
    always_comb begin
        w_rnd   = acc_q + C_HALF;
        w_shift = w_rnd >>> OUT_SHIFT;
        if (w_shift > C_MAX) begin
            w_sat = 16'sh7FFF;
        end else if (w_shift < C_MIN) begin
            w_sat = 16'sh8000;
        end else begin
            w_sat = w_shift[15:0];
        end
    end

    assign w_vchain   = {vpipe_q, issue_q};
    assign w_sweeping = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        first_d   = '0;
        second_d  = '0;
        issue_d   = 1'b0;
        vpipe_d   = w_vchain[BRAM_LATENCY-1:0];
        acc_d     = acc_q;
        out_d     = out_q;
        overrun_d = overrun_q | (sample_valid & ((state_q != S_IDLE) | ir_loading));

        if (vpipe_q[BRAM_LATENCY-1]) begin
            acc_d = acc_q + w_tap_sum;
        end

        case (state_q)
            S_IDLE: begin
                j_d = '0;
                if (sample_valid && !ir_loading) begin
                    acc_d    = '0;
                    issue_d  = 1'b1;
                    second_d = 13'd1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (j_q == C_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    j_d      = j_q + 12'd1;
                    issue_d  = 1'b1;
                    first_d  = {j_d, 1'b0};
                    second_d = {j_d, 1'b1};
                end
            end
            S_DRAIN: begin
                if (!issue_q && (vpipe_q == '0)) begin
                    out_d   = w_sat;
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loader takes over port A: drop the sweep without producing a result.
        if (ir_loading && w_sweeping) begin
            state_d  = S_IDLE;
            j_d      = '0;
            first_d  = '0;
            second_d = '0;
            issue_d  = 1'b0;
            vpipe_d  = '0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            j_q       <= '0;
            first_q   <= '0;
            second_q  <= '0;
            issue_q   <= 1'b0;
            vpipe_q   <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            first_q   <= first_d;
            second_q  <= second_d;
            issue_q   <= issue_d;
            vpipe_q   <= vpipe_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
        end
    end

    assign first_ir_index  = first_q;
    assign second_ir_index = second_q;
    assign busy            = w_sweeping;
    assign out_sample      = out_q;
    assign out_valid       = (state_q == S_OUT);
    assign overrun         = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_conv_engine.sv
//==============================================================================
// Module      : tb_ir_conv_engine
// Description : Directed self-checking bench for ir_conv_engine with
//               behavioural 2-cycle IR/history RAM models (PAIRS = 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ir_conv_engine;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic               sample_valid = 1'b0;
    logic               ir_loading   = 1'b0;
    logic [7:0][15:0]   ir_vals      = '0;
    logic [7:0][15:0]   hist_vals    = '0;
    logic [12:0]        first_ir_index;
    logic [12:0]        second_ir_index;
    logic               busy;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               overrun;

    logic [15:0] ir_mem   [4][8];
    logic [15:0] hist_mem [4][8];
    logic [12:0] a_d1 = '0;
    logic [12:0] b_d1 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ir_conv_engine #(
        .PAIRS        (4),
        .BRAM_LATENCY (2),
        .ACC_WIDTH    (52),
        .OUT_SHIFT    (15)
    ) dut (
        .audio_clk       (clk),
        .rst_in          (rst_n),
        .sample_valid    (sample_valid),
        .ir_loading      (ir_loading),
        .ir_vals         (ir_vals),
        .hist_vals       (hist_vals),
        .first_ir_index  (first_ir_index),
        .second_ir_index (second_ir_index),
        .busy            (busy),
        .out_sample      (out_sample),
        .out_valid       (out_valid),
        .overrun         (overrun)
    );

    // Two-stage read: address register, then data register.
    always @(posedge clk) begin
        a_d1 <= first_ir_index;
        b_d1 <= second_ir_index;
        for (int b = 0; b < 4; b++) begin
            ir_vals[2*b]     <= ir_mem[b][a_d1[2:0]];
            ir_vals[2*b+1]   <= ir_mem[b][b_d1[2:0]];
            hist_vals[2*b]   <= hist_mem[b][a_d1[2:0]];
            hist_vals[2*b+1] <= hist_mem[b][b_d1[2:0]];
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] iv, input logic [15:0] hv);
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 8; a++) begin
                ir_mem[b][a]   = iv;
                hist_mem[b][a] = hv;
            end
        end
    endtask

    // Called on a negedge with the engine idle; checks latency, busy width and result.
    task automatic run_sweep(input string tag, input logic signed [63:0] exp_out, input bit chk_idx);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (chk_idx && n <= 5) begin
                chk({tag, "_first_idx"},  first_ir_index,  (n <= 4) ? 2*(n-1)   : 0);
                chk({tag, "_second_idx"}, second_ir_index, (n <= 4) ? 2*(n-1)+1 : 0);
            end
            if (busy) busy_n++;
            if (out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, busy_n, 7);
        chk({tag, "_out"}, $signed(out_sample), exp_out);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, out_valid, 0);
        chk({tag, "_out_hold"}, $signed(out_sample), exp_out);
    endtask

    initial begin
        int n_ov;
        logic signed [15:0] val;

        fill(16'd4096, 16'd256);

        // Reset held with sample_valid toggling.
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sample_valid = ~sample_valid;
        end
        @(negedge clk);
        chk("rst_busy",    busy, 0);
        chk("rst_first",   first_ir_index, 0);
        chk("rst_second",  second_ir_index, 0);
        chk("rst_out",     $signed(out_sample), 0);
        chk("rst_valid",   out_valid, 0);
        chk("rst_overrun", overrun, 0);
        sample_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep("basic", 1024, 1'b1);
        chk("basic_overrun", overrun, 0);

        fill(16'h7FFF, 16'h7FFF);
        run_sweep("sat_pos", 32767, 1'b0);
        fill(16'h8000, 16'h7FFF);
        run_sweep("sat_neg", -32768, 1'b0);

        fill(16'd0, 16'd0);
        ir_mem[0][0] = 16'd128;  hist_mem[0][0] = 16'd128;
        run_sweep("rnd_half_pos", 1, 1'b0);
        ir_mem[0][0] = 16'hFF80;
        run_sweep("rnd_half_neg", 0, 1'b0);
        ir_mem[0][0] = 16'd129;  hist_mem[0][0] = 16'd127;
        run_sweep("rnd_below", 0, 1'b0);
        chk("rnd_overrun", overrun, 0);

        // Second strobe two cycles into a sweep is dropped.
        fill(16'd4096, 16'd256);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        n_ov = 0;
        val  = '0;
        repeat (30) begin
            if (out_valid) begin
                n_ov++;
                val = out_sample;
            end
            @(negedge clk);
        end
        chk("ovr_pulses",  n_ov, 1);
        chk("ovr_value",   val, 1024);
        chk("ovr_sticky",  overrun, 1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_overrun", overrun, 0);
        @(negedge clk);

        // Loader interrupts a sweep in its third cycle.
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        ir_loading = 1'b1;
        @(negedge clk);
        ir_loading = 1'b0;
        chk("abort_busy",   busy, 0);
        chk("abort_first",  first_ir_index, 0);
        chk("abort_second", second_ir_index, 0);
        n_ov = 0;
        repeat (15) begin
            if (out_valid) n_ov++;
            @(negedge clk);
        end
        chk("abort_no_out",  n_ov, 0);
        chk("abort_overrun", overrun, 0);

        run_sweep("post_abort", 1024, 1'b0);

        ir_loading   = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("load_overrun", overrun, 1);
        chk("load_busy",    busy, 0);
        ir_loading = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ir_conv_engine.md
Name: ir_conv_engine

Overview:
- Read-side sequencer and MAC for the 4-bank impulse-response buffer. On each new audio sample it sweeps both read ports of every IR bank through all addresses.
- Each cycle it multiplies the 8 returned IR taps by 8 matching history samples. The history samples come from a companion history buffer that shares the same index buses.
- Output is one rounded, saturated 16-bit convolution result per input sample, sent to the audio output path.

Parameters:
- PAIRS, 3000: read cycles per sweep. The block issues first = 2j, second = 2j+1 for j = 0..PAIRS-1, covering 2*PAIRS addresses per bank.
- BRAM_LATENCY, 2: cycles from index change to valid ir_vals / hist_vals.
- ACC_WIDTH, 52: signed accumulator width. Worst case 8*PAIRS full-scale products fits without wrap.
- OUT_SHIFT, 15: right shift from accumulator to output (Q15 scaling).

Ports:
- audio_clk  in  1  single clock for all logic.
- rst_in  in  1  synchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; a new audio sample has been written into the history buffer.
- ir_loading  in  1  high while the IR buffer is being loaded. Port A addresses are then owned by the loader.
- ir_vals  in  16 signed x8  bank read data. Entries [2b] come from port A and [2b+1] from port B of bank b.
- hist_vals  in  16 signed x8  history data at the same indices, same latency.
- first_ir_index  out  13  port-A read address for all banks.
- second_ir_index  out  13  port-B read address for all banks.
- busy  out  1  high from sweep start until out_valid.
- out_sample  out  16 signed  convolution result.
- out_valid  out  1  one-cycle strobe qualifying out_sample.
- overrun  out  1  sticky. Set when sample_valid arrives while busy or while ir_loading.

Behaviour:
- Reset (rst_in = 0 at a clock edge):
  - state = IDLE.
  - first_ir_index = 0, second_ir_index = 0.
  - busy = 0, out_sample = 0, out_valid = 0, overrun = 0.
  - Accumulator and valid pipeline cleared.
  - Reset mid-sweep aborts the sweep with no output.
- IDLE:
  - Indices held at 0.
  - sample_valid & !ir_loading: clear accumulator, j = 0, go to ISSUE, busy = 1 next cycle.
  - sample_valid & ir_loading: ignored; overrun set.
- ISSUE:
  - first_ir_index = 2j, second_ir_index = 2j+1.
  - Issue bit enters a BRAM_LATENCY-deep valid shift register.
  - j increments each cycle. After j = PAIRS-1 go to DRAIN; indices return to 0.
- DRAIN: wait until the valid pipeline is empty (BRAM_LATENCY cycles), then go to OUT.
- Accumulate: each cycle the delayed valid is high, acc += sum over i = 0..7 of ir_vals[i]*hist_vals[i].
  - Each product is signed 16x16 -> 32 bits.
  - The adder tree is sign-extended to ACC_WIDTH.
  - No intermediate truncation.
  - Adder tree may be registered internally only if BRAM_LATENCY accounting is extended to match. Result timing is unchanged at the ports.
- OUT:
  - out_sample = sat16((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT), i.e. round half up (toward +inf).
  - Saturate to [-32768, 32767].
  - out_valid = 1 for one cycle, then IDLE and busy = 0.
  - out_sample holds its value until the next OUT.
- Latency: sample_valid sampled at edge 0 -> out_valid high for cycle PAIRS + BRAM_LATENCY + 2. This is 3004 with the defaults.
- sample_valid while busy: dropped, overrun set, current sweep unaffected. Simultaneous with out_valid counts as busy (dropped).
- ir_loading rising mid-sweep (ISSUE or DRAIN):
  - Abort: state = IDLE, indices 0, valid pipeline and accumulator cleared, busy = 0.
  - No out_valid.
  - overrun is not affected.
- overrun clears only on reset.

Test Plan (PAIRS = 4, BRAM_LATENCY = 2, behavioural 2-cycle RAM models):
- Reset: hold rst_in = 0 for 3 cycles with sample_valid toggling -> all outputs 0, busy = 0, indices 0.
- Basic sweep: all IR = 4096, all hist = 256, one sample_valid.
  - Indices step (0,1), (2,3), (4,5), (6,7), then return to 0.
  - busy high 7 cycles, out_valid at cycle 8 with out_sample = 1024.
- Saturation:
  - IR = 32767, hist = 32767 -> 32767.
  - IR = -32768, hist = 32767 -> -32768.
- Rounding: program a single product pair giving acc = 16384 -> out 1; acc = -16384 -> out 0; acc = 16383 -> out 0.
- Overrun: second sample_valid 2 cycles after the first -> exactly one out_valid, value 1024, overrun = 1 thereafter.
- Abort:
  - ir_loading pulsed in cycle 3 of a sweep -> no out_valid, busy drops next cycle, indices 0.
  - Next sample_valid after ir_loading falls -> correct result 1024.
  - sample_valid during ir_loading -> overrun = 1.
